text_console: RTL and testbench

Parametrised character console controller: the successor of the fixed-size text path between the CPU and the character generator. It accepts character codes from the CPU over a valid/ready handshake. It owns the cursor and a circular text RAM with hardware scrolling, and interprets control codes. On the display side it turns the VGA dot/scanline counters into a pipelined character code, glyph coordinates and a blinking cursor flag for the character generator.

---
 rtl/console_pkg.sv | 24 ++
 rtl/text_ram.sv | 31 +++
 rtl/text_console.sv | 247 ++++++++++++++++++++++++
 tb/tb_text_console.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared definitions for the text console: control codes, FSM states and width helper.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package console_pkg;

    // Character codes interpreted by the console (8-bit; resized to CODE_W at use).
    localparam logic [7:0] CODE_NL    = 8'h0A;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_FF    = 8'h0C;
    localparam logic [7:0] CODE_SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } state_t;

    // Index width for n items; never zero so single-entry dimensions still get a bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/text_ram.sv
// Text character store: one write port, one registered read port, contents not reset.
// Latency: read data valid one cycle after raddr; same-address read/write returns old data.
// Backpressure: none, both ports accept every cycle.
//   clk   : clock          we/waddr/wdata : write port
//   raddr : read address   rdata          : registered read data
module text_ram #(
    parameter int DEPTH = 2400,
    parameter int WIDTH = 8,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_console.sv
// Character console: CPU char stream -> cursor/scrolling text RAM -> glyph stream for the char generator.
// Latency: CPU write lands in RAM one edge after accept; display path is 2 cycles (addr reg, RAM reg).
// Backpressure: char_ready low while clearing (whole screen after reset/FF, one row after a scroll).
//   clk, rst                         : clock, synchronous active-high reset
//   char_in/char_valid/char_ready    : CPU character handshake
//   cursor_x, cursor_y               : cursor column / logical row
//   dot_counter, scanline_counter    : display pixel position
//   char_out, glyph_col, glyph_row   : code and glyph coordinates, 2 cycles after the position
//   cursor_here                      : aligned cell is the cursor and blink phase is on
module text_console
    import console_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CODE_W       = 8,
    parameter int GLYPH_W      = 8,
    parameter int GLYPH_H      = 16,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CODE_W-1:0]            char_in,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [idx_w(COLS)-1:0]       cursor_x,
    output logic [idx_w(ROWS)-1:0]       cursor_y,
    input  logic [9:0]                   dot_counter,
    input  logic [9:0]                   scanline_counter,
    output logic [CODE_W-1:0]            char_out,
    output logic [idx_w(GLYPH_W)-1:0]    glyph_col,
    output logic [idx_w(GLYPH_H)-1:0]    glyph_row,
    output logic                         cursor_here
);

    localparam int COL_W  = idx_w(COLS);
    localparam int ROW_W  = idx_w(ROWS);
    localparam int ADDR_W = idx_w(ROWS * COLS);
    localparam int GC_W   = idx_w(GLYPH_W);
    localparam int GR_W   = idx_w(GLYPH_H);
    localparam int FR_W   = idx_w(BLINK_FRAMES);
    localparam int GC_SH  = $clog2(GLYPH_W);
    localparam int GR_SH  = $clog2(GLYPH_H);

    localparam logic [CODE_W-1:0] SPACE = CODE_W'(CODE_SPACE);

    // Logical row -> RAM address. Both operands are < ROWS, so one
    // conditional subtract is enough to wrap the physical row.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] lrow,
                                                    input logic [ROW_W-1:0] top,
                                                    input logic [COL_W-1:0] col);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return ADDR_W'(sum) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    state_t              state_q, state_n;
    logic [ROW_W-1:0]    top_row;
    logic [ADDR_W-1:0]   clr_cnt;

    // Character decode
    logic accept, is_nl, is_cr, is_bs, is_ff, printable, wrap, last_row, scroll;

    assign accept    = char_valid && char_ready;
    assign is_nl     = (char_in == CODE_W'(CODE_NL));
    assign is_cr     = (char_in == CODE_W'(CODE_CR));
    assign is_bs     = (char_in == CODE_W'(CODE_BS));
    assign is_ff     = (char_in == CODE_W'(CODE_FF));
    assign printable = !(is_nl || is_cr || is_bs || is_ff);
    assign wrap      = printable && (cursor_x == COL_W'(COLS - 1));
    assign last_row  = (cursor_y == ROW_W'(ROWS - 1));
    assign scroll    = accept && (is_nl || wrap) && last_row;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ALL;
        end else begin
            state_q <= state_n;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n = state_q;
        case (state_q)
            CLEAR_ALL: if (clr_cnt == ADDR_W'(ROWS * COLS - 1)) state_n = IDLE;
            IDLE: begin
                if (accept && is_ff)  state_n = CLEAR_ALL;
                else if (scroll)      state_n = CLEAR_ROW;
            end
            CLEAR_ROW: if (clr_cnt == ADDR_W'(COLS - 1)) state_n = IDLE;
            default: state_n = CLEAR_ALL;
        endcase
    end

    // ---------------- FSM: outputs / RAM write port ----------------
    logic                we;
    logic [CODE_W-1:0]   wdata;
    logic [ADDR_W-1:0]   waddr;
    logic [COL_W-1:0]    wcol;

    always_comb begin
        char_ready = 1'b0;
        we         = 1'b0;
        wdata      = SPACE;
        wcol       = cursor_x;
        waddr      = '0;
        case (state_q)
            CLEAR_ALL: begin
                we    = 1'b1;
                waddr = clr_cnt;
            end
            IDLE: begin
                char_ready = 1'b1;
                we         = accept && (printable || (is_bs && cursor_x != '0));
                wdata      = printable ? char_in : SPACE;
                wcol       = is_bs ? cursor_x - COL_W'(1) : cursor_x;
                waddr      = cell_addr(cursor_y, top_row, wcol);
            end
            CLEAR_ROW: begin
                // top_row has already advanced, so logical row ROWS-1
                // (where the cursor sits) is the old top physical row.
                we    = 1'b1;
                wcol  = clr_cnt[COL_W-1:0];
                waddr = cell_addr(cursor_y, top_row, wcol);
            end
            default: ;
        endcase
    end

    // Clear counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || state_n != state_q) begin
            clr_cnt <= '0;
        end else if (state_q != IDLE) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    // ---------------- Cursor and scroll origin ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cursor_x <= '0;
            cursor_y <= '0;
            top_row  <= '0;
        end else if (accept) begin
            if (is_ff) begin
                cursor_x <= '0;
                cursor_y <= '0;
                top_row  <= '0;
            end else if (is_cr) begin
                cursor_x <= '0;
            end else if (is_bs) begin
                if (cursor_x != '0) cursor_x <= cursor_x - COL_W'(1);
            end else if (is_nl || wrap) begin
                cursor_x <= '0;
                if (last_row) begin
                    top_row <= (top_row == ROW_W'(ROWS - 1)) ? '0 : top_row + ROW_W'(1);
                end else begin
                    cursor_y <= cursor_y + ROW_W'(1);
                end
            end else begin
                cursor_x <= cursor_x + COL_W'(1);
            end
        end
    end

    // ---------------- Blink ----------------
    logic [FR_W-1:0] frame_cnt;
    logic            blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (dot_counter == '0 && scanline_counter == '0) begin
            if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + FR_W'(1);
            end
        end
    end

    // ---------------- Display read pipeline ----------------
    logic [9:0]        dcol, drow;
    logic              in_range;
    logic [ADDR_W-1:0] raddr_q;
    logic [CODE_W-1:0] rdata;
    logic              s1_vld, s2_vld, s1_cur, s2_cur;
    logic [GC_W-1:0]   s1_gcol;
    logic [GR_W-1:0]   s1_grow;

    assign dcol     = dot_counter >> GC_SH;
    assign drow     = scanline_counter >> GR_SH;
    assign in_range = (dcol < 10'(COLS)) && (drow < 10'(ROWS));

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q     <= '0;
            s1_vld      <= 1'b0;
            s1_cur      <= 1'b0;
            s1_gcol     <= '0;
            s1_grow     <= '0;
            s2_vld      <= 1'b0;
            cursor_here <= 1'b0;
            glyph_col   <= '0;
            glyph_row   <= '0;
        end else begin
            raddr_q     <= in_range ? cell_addr(drow[ROW_W-1:0], top_row, dcol[COL_W-1:0]) : '0;
            s1_vld      <= in_range;
            s1_cur      <= in_range && blink_on
                           && dcol == 10'(cursor_x) && drow == 10'(cursor_y);
            s1_gcol     <= dot_counter[GC_W-1:0];
            s1_grow     <= scanline_counter[GR_W-1:0];
            s2_vld      <= s1_vld;
            cursor_here <= s1_cur;
            glyph_col   <= s1_gcol;
            glyph_row   <= s1_grow;
        end
    end

    assign s2_cur   = cursor_here;
    assign char_out = s2_vld ? rdata : SPACE;

    text_ram #(
        .DEPTH (ROWS * COLS),
        .WIDTH (CODE_W),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr_q),
        .rdata (rdata)
    );

    // s2_cur kept as a named alias of the aligned cursor flag for readability in waves.
    logic unused_ok;
    assign unused_ok = s2_cur;

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic [9:0] dot_counter;
    logic [9:0] scanline_counter;
    logic [7:0] char_out;
    logic [2:0] glyph_col;
    logic [3:0] glyph_row;
    logic       cursor_here;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_console dut (
        .clk              (clk),
        .rst              (rst),
        .char_in          (char_in),
        .char_valid       (char_valid),
        .char_ready       (char_ready),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .dot_counter      (dot_counter),
        .scanline_counter (scanline_counter),
        .char_out         (char_out),
        .glyph_col        (glyph_col),
        .glyph_row        (glyph_row),
        .cursor_here      (cursor_here)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        while (char_ready !== 1'b1 && n < 10000) begin
            tick;
            n++;
        end
        if (char_ready !== 1'b1) chk("send_ready_timeout", {31'd0, char_ready}, 32'd1);
        char_in    = c;
        char_valid = 1'b1;
        tick;
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    // Number of sampled cycles char_ready stays low, bounded.
    task automatic count_low(output int n);
        n = 0;
        while (char_ready === 1'b0 && n < 5000) begin
            tick;
            n++;
        end
    endtask

    task automatic read_cell(input int col, input int row, output logic [7:0] code);
        dot_counter      = 10'(col * 8);
        scanline_counter = 10'(row * 16);
        tick;
        tick;
        code = char_out;
    endtask

    task automatic frame_pulse;
        dot_counter      = 10'd0;
        scanline_counter = 10'd0;
        tick;
        dot_counter      = 10'd40;
        tick;
        tick;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] code;

        rst              = 1'b1;
        char_in          = 8'h00;
        char_valid       = 1'b0;
        dot_counter      = 10'd700;
        scanline_counter = 10'd700;

        // ---- Reset state ----
        tick;
        chk("rst_ready", {31'd0, char_ready}, 0);
        chk("rst_cx", {25'd0, cursor_x}, 0);
        chk("rst_cy", {27'd0, cursor_y}, 0);
        chk("rst_char_out", {24'd0, char_out}, 32'h20);
        chk("rst_gcol", {29'd0, glyph_col}, 0);
        chk("rst_grow", {28'd0, glyph_row}, 0);
        chk("rst_cur_here", {31'd0, cursor_here}, 0);
        tick;
        rst = 1'b0;
        count_low(n);
        chk("init_clear_len", n, 2400);

        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++) begin
                read_cell(c, r, code);
                chk("init_cell", {24'd0, code}, 32'h20);
            end
        chk("init_cx", {25'd0, cursor_x}, 0);
        chk("init_cy", {27'd0, cursor_y}, 0);

        // ---- "AB" CR "C" ----
        send(8'h41); send(8'h42); send(8'h0D); send(8'h43);
        chk("abc_cx", {25'd0, cursor_x}, 1);
        chk("abc_cy", {27'd0, cursor_y}, 0);
        read_cell(0, 0, code); chk("abc_cell00", {24'd0, code}, 32'h43);
        read_cell(1, 0, code); chk("abc_cell10", {24'd0, code}, 32'h42);

        // ---- 80 chars wrap, BS at column 0 ----
        send(8'h0D);
        for (int i = 0; i < 80; i++) send(8'(8'h61 + i % 26));
        chk("wrap_cx", {25'd0, cursor_x}, 0);
        chk("wrap_cy", {27'd0, cursor_y}, 1);
        read_cell(79, 0, code); chk("wrap_cell79", {24'd0, code}, 32'h62);
        read_cell(0, 0, code);  chk("wrap_cell0", {24'd0, code}, 32'h61);
        send(8'h08);
        chk("bs0_cx", {25'd0, cursor_x}, 0);
        chk("bs0_cy", {27'd0, cursor_y}, 1);
        read_cell(0, 1, code);  chk("bs0_cell01", {24'd0, code}, 32'h20);
        read_cell(79, 0, code); chk("bs0_cell79", {24'd0, code}, 32'h62);
        send(8'h58);
        chk("x_cx", {25'd0, cursor_x}, 1);
        read_cell(0, 1, code);  chk("x_cell01", {24'd0, code}, 32'h58);
        send(8'h08);
        chk("bs_cx", {25'd0, cursor_x}, 0);
        read_cell(0, 1, code);  chk("bs_cell01", {24'd0, code}, 32'h20);

        // ---- Display coordinates with 'Q' at (2,2) ----
        send(8'h41); send(8'h0A);
        chk("nl_cx", {25'd0, cursor_x}, 0);
        chk("nl_cy", {27'd0, cursor_y}, 2);
        send(8'h78); send(8'h79); send(8'h51);
        dot_counter      = 10'd17;
        scanline_counter = 10'd35;
        tick; tick;
        chk("disp_char", {24'd0, char_out}, 32'h51);
        chk("disp_gcol", {29'd0, glyph_col}, 1);
        chk("disp_grow", {28'd0, glyph_row}, 3);
        dot_counter = 10'd645;
        tick; tick;
        chk("disp_oob_char", {24'd0, char_out}, 32'h20);
        chk("disp_oob_gcol", {29'd0, glyph_col}, 5);
        chk("disp_oob_cur", {31'd0, cursor_here}, 0);

        // ---- Fill to last row, NL scrolls ----
        send(8'h0A);
        for (int r = 3; r < 30; r++) begin
            send(8'(8'h40 + r));
            if (r < 29) send(8'h0A);
        end
        chk("fill_cx", {25'd0, cursor_x}, 1);
        chk("fill_cy", {27'd0, cursor_y}, 29);
        send(8'h0A);
        count_low(n);
        chk("scroll_low_len", n, 80);
        chk("scroll_cx", {25'd0, cursor_x}, 0);
        chk("scroll_cy", {27'd0, cursor_y}, 29);
        for (int c = 0; c < 80; c++) begin
            read_cell(c, 29, code);
            chk("scroll_row29", {24'd0, code}, 32'h20);
        end
        read_cell(0, 0, code);  chk("scroll_r0c0", {24'd0, code}, 32'h41);
        read_cell(1, 0, code);  chk("scroll_r0c1", {24'd0, code}, 32'h20);
        read_cell(2, 1, code);  chk("scroll_r1c2", {24'd0, code}, 32'h51);
        read_cell(0, 28, code); chk("scroll_r28", {24'd0, code}, 32'h5D);
        read_cell(0, 27, code); chk("scroll_r27", {24'd0, code}, 32'h5C);

        // ---- Printable wrap on last row also scrolls ----
        for (int i = 0; i < 80; i++) send(8'h7A);
        count_low(n);
        chk("wscroll_low_len", n, 80);
        chk("wscroll_cx", {25'd0, cursor_x}, 0);
        chk("wscroll_cy", {27'd0, cursor_y}, 29);
        read_cell(79, 28, code); chk("wscroll_r28", {24'd0, code}, 32'h7A);
        read_cell(0, 29, code);  chk("wscroll_r29", {24'd0, code}, 32'h20);
        read_cell(0, 0, code);   chk("wscroll_r0c0", {24'd0, code}, 32'h78);
        read_cell(2, 0, code);   chk("wscroll_r0c2", {24'd0, code}, 32'h51);

        // ---- Reset mid-clear restarts the full clear ----
        dot_counter      = 10'd700;
        scanline_counter = 10'd700;
        send(8'h0C);
        for (int i = 0; i < 100; i++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        count_low(n);
        chk("rst_mid_clear_len", n, 2400);

        // ---- Blink with cursor at (5,0) ----
        send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
        chk("blink_cx", {25'd0, cursor_x}, 5);
        dot_counter      = 10'd40;
        scanline_counter = 10'd0;
        tick; tick;
        chk("blink_on0", {31'd0, cursor_here}, 1);
        chk("blink_cell", {24'd0, char_out}, 32'h20);
        for (int i = 0; i < 29; i++) frame_pulse;
        chk("blink_on29", {31'd0, cursor_here}, 1);
        frame_pulse;
        chk("blink_off30", {31'd0, cursor_here}, 0);
        for (int i = 0; i < 30; i++) frame_pulse;
        chk("blink_on60", {31'd0, cursor_here}, 1);

        // ---- FF mid-frame ----
        send(8'h0C);
        chk("ff_cx", {25'd0, cursor_x}, 0);
        chk("ff_cy", {27'd0, cursor_y}, 0);
        count_low(n);
        chk("ff_clear_len", n, 2400);
        read_cell(0, 0, code); chk("ff_cell00", {24'd0, code}, 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
